// File: rtl/rf_pkg.sv
// Shared definitions for the regfile writeback arbiter.
//   XLEN   : register data width
//   REG_AW : register index width
//   NREGS  : number of architectural registers
//   wb_req_t : one buffered writeback {rd, data}
//   wb_src_e : writeback source identifier
package rf_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_e;

  // One-hot register mask used to build the pending-write mask.
  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    return NREGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// Single-entry writeback holding slot with a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : source request
//   in_req      : source {rd, data}
//   grant       : the arbiter drains this slot to the regfile this cycle
//   ready       : slot can accept this cycle (empty, or being drained)
//   fill        : this cycle's handshake will load the slot on the next edge
//   held_valid  : slot holds a write
//   held        : buffered {rd, data}
// A handshake with rd == 0 completes but is discarded (x0 is hardwired).
module wb_slot
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    fill,
  output logic    held_valid,
  output wb_req_t held
);

  // Draining and refilling on the same edge keeps full throughput.
  assign ready = !held_valid || grant;
  assign fill  = in_valid && ready && (in_req.rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
    end else if (fill) begin
      held_valid <= 1'b1;
    end else if (grant) begin
      held_valid <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only observed while held_valid=1,
  // so resetting it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (fill) begin
      held <= in_req;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between the ALU and MEM writeback
// sources. Each source feeds a one-entry wb_slot; an age-based arbiter drains
// one slot per cycle. Also exports the pending-write mask and, optionally,
// forwards buffered data to the two read ports.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data       : ALU writeback handshake
//   mem_valid/ready/rd/data       : MEM (load) writeback handshake
//   write, writenum, write_data   : regfile write port (from slot registers only)
//   pend_mask                     : bit i set while a slot holds a write to reg i
//   rd_num1/2, fwd_hit1/2, fwd_data1/2 : forwarding lookup
// Build option: define WB_FWD_EN to build the forwarding compare logic;
// otherwise fwd_hit*/fwd_data* are tied to zero.
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              write,
  output logic [REG_AW-1:0] writenum,
  output logic [XLEN-1:0]   write_data,
  output logic [NREGS-1:0]  pend_mask,
  input  logic [REG_AW-1:0] rd_num1,
  input  logic [REG_AW-1:0] rd_num2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
);

  logic    alu_held_valid, mem_held_valid;
  wb_req_t alu_held, mem_held;
  logic    alu_fill, mem_fill;
  logic    alu_grant, mem_grant;
  logic    mem_older;  // meaningful only while both slots are valid
  wb_src_e winner;

  wb_slot u_alu_slot (
    .clk(clk), .rst_n(rst_n), .in_valid(alu_valid),
    .in_req('{rd: alu_rd, data: alu_data}), .grant(alu_grant),
    .ready(alu_ready), .fill(alu_fill),
    .held_valid(alu_held_valid), .held(alu_held)
  );

  wb_slot u_mem_slot (
    .clk(clk), .rst_n(rst_n), .in_valid(mem_valid),
    .in_req('{rd: mem_rd, data: mem_data}), .grant(mem_grant),
    .ready(mem_ready), .fill(mem_fill),
    .held_valid(mem_held_valid), .held(mem_held)
  );

  // A fresh ALU entry is always the younger one: either MEM was already
  // waiting, or MEM filled on the same edge and is older in program order.
  // A fresh MEM entry alone is younger than any ALU entry left behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_older <= 1'b0;
    end else if (alu_fill) begin
      mem_older <= 1'b1;
    end else if (mem_fill) begin
      mem_older <= 1'b0;
    end
  end

  always_comb begin
    winner = (mem_held_valid && (!alu_held_valid || mem_older)) ? SRC_MEM : SRC_ALU;
  end

  assign mem_grant = mem_held_valid && (winner == SRC_MEM);
  assign alu_grant = alu_held_valid && (winner == SRC_ALU);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    write      = 1'b0;
    writenum   = '0;
    write_data = '0;
    if (mem_grant) begin
      write      = 1'b1;
      writenum   = mem_held.rd;
      write_data = mem_held.data;
    end else if (alu_grant) begin
      write      = 1'b1;
      writenum   = alu_held.rd;
      write_data = alu_held.data;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (alu_held_valid) pend_mask = pend_mask | rd_onehot(alu_held.rd);
    if (mem_held_valid) pend_mask = pend_mask | rd_onehot(mem_held.rd);
  end

`ifdef WB_FWD_EN
  logic [REG_AW-1:0] fwd_num  [2];
  logic              fwd_hit  [2];
  logic [XLEN-1:0]   fwd_data [2];

  assign fwd_num[0] = rd_num1;
  assign fwd_num[1] = rd_num2;

  // When both slots match, the younger slot carries the newer value.
  for (genvar k = 0; k < 2; k++) begin : g_fwd
    logic alu_match, mem_match;
    assign alu_match = alu_held_valid && (alu_held.rd == fwd_num[k]) && (fwd_num[k] != '0);
    assign mem_match = mem_held_valid && (mem_held.rd == fwd_num[k]) && (fwd_num[k] != '0);

    always_comb begin
      fwd_hit[k]  = alu_match || mem_match;
      fwd_data[k] = '0;
      if (alu_match && mem_match) begin
        fwd_data[k] = mem_older ? alu_held.data : mem_held.data;
      end else if (alu_match) begin
        fwd_data[k] = alu_held.data;
      end else if (mem_match) begin
        fwd_data[k] = mem_held.data;
      end
    end
  end

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data1 = fwd_data[0];
  assign fwd_data2 = fwd_data[1];
`else
  logic unused_rd_num;
  assign unused_rd_num = ^{rd_num1, rd_num2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A behavioural model keeps each
// slot as {valid, rd, data, fill sequence number}; the oldest entry (lowest
// sequence number, MEM numbered first on a shared edge) drains each cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rd_num1, rd_num2, writenum;
  logic [63:0] alu_data, mem_data, write_data, fwd_data1, fwd_data2;
  logic        write, fwd_hit1, fwd_hit2;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write(write), .writenum(writenum), .write_data(write_data), .pend_mask(pend_mask),
    .rd_num1(rd_num1), .rd_num2(rd_num2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [63:0] data;
    int unsigned seq;
  } mslot_t;

  mslot_t      ms [2];      // 0 = MEM, 1 = ALU
  int unsigned seq_ctr;
  logic [63:0] mdl_rf [32];
  logic [63:0] dut_rf [32];
  int          dut_writes;
  bit          acc_alu, acc_mem;
  bit          cmp_en;

  function automatic int mdl_grant();
    if (ms[0].v && ms[1].v) return (ms[0].seq < ms[1].seq) ? 0 : 1;
    if (ms[0].v) return 0;
    if (ms[1].v) return 1;
    return -1;
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) ms[i] = '{v: 0, rd: '0, data: '0, seq: 0};
  endfunction

  // Called right after each rising edge; inputs are still the values sampled.
  task automatic model_edge();
    int g;
    g = mdl_grant();
    acc_mem = mem_valid && (!ms[0].v || g == 0);
    acc_alu = alu_valid && (!ms[1].v || g == 1);
    if (g >= 0) begin
      mdl_rf[ms[g].rd] = ms[g].data;
      ms[g].v = 0;
    end
    if (acc_mem && mem_rd != 0) begin
      ms[0] = '{v: 1, rd: mem_rd, data: mem_data, seq: seq_ctr};
      seq_ctr++;
    end
    if (acc_alu && alu_rd != 0) begin
      ms[1] = '{v: 1, rd: alu_rd, data: alu_data, seq: seq_ctr};
      seq_ctr++;
    end
  endtask

  function automatic void exp_fwd(input logic [4:0] num, output logic hit, output logic [63:0] data);
    int best;
    hit = 0; data = '0; best = -1;
`ifdef WB_FWD_EN
    for (int i = 0; i < 2; i++)
      if (ms[i].v && num != 0 && ms[i].rd == num && (best < 0 || ms[i].seq > ms[best].seq)) best = i;
    if (best >= 0) begin hit = 1; data = ms[best].data; end
`endif
  endfunction

  // Single compare process: outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      int          g;
      logic [31:0] m;
      logic        h;
      logic [63:0] d;
      g = mdl_grant();
      m = '0;
      for (int i = 0; i < 2; i++) if (ms[i].v) m[ms[i].rd] = 1'b1;
      check("write", write, g >= 0);
      check("writenum", writenum, g >= 0 ? 64'(ms[g].rd) : 64'd0);
      check("write_data", write_data, g >= 0 ? ms[g].data : 64'd0);
      check("pend_mask", pend_mask, m);
      check("mem_ready", mem_ready, !ms[0].v || g == 0);
      check("alu_ready", alu_ready, !ms[1].v || g == 1);
      exp_fwd(rd_num1, h, d);
      check("fwd_hit1", fwd_hit1, h);
      check("fwd_data1", fwd_data1, d);
      exp_fwd(rd_num2, h, d);
      check("fwd_hit2", fwd_hit2, h);
      check("fwd_data2", fwd_data2, d);
      if (write) begin
        dut_rf[writenum] = write_data;
        dut_writes++;
      end
    end
  end

  task automatic drive(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [63:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [63:0] md);
    drive(av, ard, ad, mv, mrd, md);
    tick();
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    int w0;
    rst_n = 1'b0; cmp_en = 0; seq_ctr = 0; dut_writes = 0;
    rd_num1 = 0; rd_num2 = 0;
    drive(0, 0, 0, 0, 0, 0);
    mdl_reset();
    for (int i = 0; i < 32; i++) begin mdl_rf[i] = '0; dut_rf[i] = '0; end
    #3;
    check("reset write", write, 0);
    check("reset writenum", writenum, 0);
    check("reset write_data", write_data, 0);
    check("reset pend_mask", pend_mask, 0);
    check("reset fwd_hit1", fwd_hit1, 0);
    check("reset fwd_data2", fwd_data2, 0);
    #9 rst_n = 1'b1;
    cmp_en = 1;
    check("ready after reset", {alu_ready, mem_ready}, 2'b11);

    // Single write
    step(1, 1, 42, 0, 0, 0);
    check("single write", write, 1);
    check("single writenum", writenum, 1);
    check("single data", write_data, 42);
    check("single pend", pend_mask, 32'h2);
    idle();
    check("single pend clear", pend_mask, 0);
    check("single write clear", write, 0);

    // x0 drop
    check("x0 mem_ready", mem_ready, 1);
    step(0, 0, 0, 1, 0, 100);
    check("x0 no write", write, 0);
    check("x0 pend", pend_mask, 0);
    idle();

    // Same-edge conflict: MEM first
    step(1, 2, 84, 1, 3, 7);
    check("conflict first num", writenum, 3);
    check("conflict first data", write_data, 7);
    check("conflict pend", pend_mask, 32'hC);
    check("conflict alu_ready", alu_ready, 0);
    idle();
    check("conflict second num", writenum, 2);
    check("conflict second data", write_data, 84);
    check("conflict pend 2", pend_mask, 32'h4);
    check("conflict alu_ready 2", alu_ready, 1);
    idle();
    check("conflict pend 3", pend_mask, 0);

    // Same rd: MEM value then ALU value, ALU value survives
    step(1, 5, 1, 1, 5, 2);
    check("same rd first data", write_data, 2);
    idle();
    check("same rd second data", write_data, 1);
    idle();
    check("same rd final", dut_rf[5], 1);

    // Back-to-back ALU
    for (int k = 1; k <= 4; k++) begin
      check("b2b ready before", alu_ready, 1);
      step(1, 5'(k), 64'(k * 10), 0, 0, 0);
      check("b2b writenum", writenum, k);
      check("b2b data", write_data, k * 10);
    end
    idle();
    idle();

    // Randomized traffic honouring the hold rule
    acc_alu = 1; acc_mem = 1;
    for (int c = 0; c < 2000; c++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd = 5'($urandom_range(0, 7)); alu_data = {$urandom, $urandom};
      end
      if (!mem_valid || acc_mem) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_rd = 5'($urandom_range(0, 7)); mem_data = {$urandom, $urandom};
      end
      rd_num1 = 5'($urandom_range(0, 7));
      rd_num2 = 5'($urandom_range(0, 7));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) tick();
    for (int i = 0; i < 32; i++) check("regfile contents", dut_rf[i], mdl_rf[i]);

    // Reset mid-operation with both slots full
    rd_num1 = 7; rd_num2 = 6;
    step(1, 6, 64'h66, 1, 7, 64'h77);
    check("pre-reset write", write, 1);
    check("pre-reset pend", pend_mask, 32'hC0);
`ifdef WB_FWD_EN
    check("pre-reset fwd_hit1", fwd_hit1, 1);
    check("pre-reset fwd_data1", fwd_data1, 64'h77);
`else
    check("pre-reset fwd_hit1", fwd_hit1, 0);
`endif
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    check("async reset write", write, 0);
    check("async reset pend", pend_mask, 0);
    check("async reset fwd_hit1", fwd_hit1, 0);
    w0 = dut_writes;
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check("no write after reset", dut_writes - w0, 0);
    check("pend after reset", pend_mask, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
